// File: rtl/online_pkg.sv
// Shared definitions for the online-arithmetic datapath blocks.
// Holds the radix-2 signed-digit encoding {plus,minus} and the
// collect/hold state type used by the serial-to-parallel converters.
package online_pkg;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_ILL  = 2'b11;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/online_otf_step.sv
// One step of on-the-fly conversion: appends a signed digit to the
// running pair (Q, QM = Q - ulp) within a fixed W-bit window.
// Ports:
//   q, qm           current Q and QM registers (W bits)
//   digit           signed digit {plus,minus}; 11 is handled as 0
//   q_next, qm_next updated Q and QM
module online_otf_step
  import online_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  localparam logic [W-1:0] ONE = W'(1);

  // Shifting left inside W bits drops the MSB; appending a 1 is an OR.
  logic [W-1:0] q_sh;
  logic [W-1:0] qm_sh;

  assign q_sh  = q << 1;
  assign qm_sh = qm << 1;

  always_comb begin
    q_next  = q_sh;
    qm_next = qm_sh | ONE;
    unique case (digit)
      DIG_POS: begin
        q_next  = q_sh | ONE;
        qm_next = q_sh;
      end
      DIG_NEG: begin
        q_next  = qm_sh | ONE;
        qm_next = qm_sh;
      end
      DIG_ZERO, DIG_ILL: begin
        q_next  = q_sh;
        qm_next = qm_sh | ONE;
      end
      default: begin
        q_next  = q_sh;
        qm_next = qm_sh | ONE;
      end
    endcase
  end

endmodule

// File: rtl/online_otf_convert.sv
// Serial MSD-first signed-digit to two's-complement converter.
// Collects Stage radix-2 signed digits per word and presents the
// integer sum d_i*2^(Stage-i) as a registered (Stage+1)-bit word.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clr             synchronous abort of the current word (as rst)
//   in_valid/ready  digit handshake; in_digit is {plus,minus}
//   out_valid/ready word handshake; out_data, out_err held while stalled
module online_otf_convert
  import online_pkg::*;
#(
  parameter int Stage = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_digit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Stage:0]   out_data,
  output logic             out_err
);

  localparam int W  = Stage + 1;
  localparam int CW = $clog2(Stage + 1);
  localparam logic [CW-1:0] LAST = CW'(Stage - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   q_q, qm_q;
  logic [W-1:0]   q_step, qm_step;
  logic           err_q;
  logic           accept;
  logic           release_word;

  online_otf_step #(.W(W)) u_step (
    .q       (q_q),
    .qm      (qm_q),
    .digit   (in_digit),
    .q_next  (q_step),
    .qm_next (qm_step)
  );

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;
    release_word = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (cnt_q == LAST)) state_d = HOLD;
      end
      HOLD: begin
        out_valid    = 1'b1;
        release_word = out_ready;
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= COLLECT;
    else            state_q <= state_d;
  end

  // Releasing a held word and aborting share the same reinitialisation,
  // so each new word starts from Q=0, QM=-1 with a clean error flag.
  always_ff @(posedge clk) begin
    if (rst || clr || release_word) begin
      cnt_q <= '0;
      q_q   <= '0;
      qm_q  <= '1;
      err_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
      q_q   <= q_step;
      qm_q  <= qm_step;
      err_q <= err_q | (in_digit == DIG_ILL);
    end
  end

  assign out_data = q_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_online_otf_convert.sv
// Self-checking bench for online_otf_convert (Stage=4): directed words,
// abort cases, and a randomized stream checked against an arithmetic model.
module tb_online_otf_convert;

  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst, clr, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]   in_digit;
  logic [S:0]   out_data;

  int n_cmp = 0;
  int n_err = 0;

  online_otf_convert #(.Stage(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain weighted sum of signed digits, digit 1 first in w[2S-1:2S-2].
  function automatic int ref_sum(input logic [2*S-1:0] w);
    int s = 0;
    for (int i = 1; i <= S; i++) begin
      logic [1:0] d = w[2*(S-i) +: 2];
      if (d == 2'b10) s += (1 << (S - i));
      else if (d == 2'b01) s -= (1 << (S - i));
    end
    return s;
  endfunction

  function automatic int ref_err(input logic [2*S-1:0] w);
    int e = 0;
    for (int i = 0; i < S; i++)
      if (w[2*i +: 2] == 2'b11) e = 1;
    return e;
  endfunction

  // Called at a negedge; leaves the bench at the negedge after acceptance.
  task automatic push(input logic [1:0] d, input int gap, input logic do_clr);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_digit = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_digit = d;
    clr      = do_clr;
    check_eq("in_ready_collect", int'(in_ready), 1);
    check_eq("no_early_valid", int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic send_word(input logic [2*S-1:0] w, input int max_gap);
    for (int i = 1; i <= S; i++) begin
      int gap = 0;
      if (max_gap > 0 && $urandom_range(0, 7) == 0) gap = $urandom_range(1, max_gap);
      push(w[2*(S-i) +: 2], gap, 1'b0);
    end
  endtask

  // Expects out_valid right after the last digit; stalls, then releases.
  task automatic take_word(input string tag, input int exp_val, input int exp_err,
                           input int stall);
    check_eq({tag, "_valid"}, int'(out_valid), 1);
    check_eq({tag, "_data"}, int'($signed(out_data)), exp_val);
    check_eq({tag, "_err"}, int'(out_err), exp_err);
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      in_digit  = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_stall_ready"}, int'(in_ready), 0);
      check_eq({tag, "_stall_valid"}, int'(out_valid), 1);
      check_eq({tag, "_stall_data"}, int'($signed(out_data)), exp_val);
      check_eq({tag, "_stall_err"}, int'(out_err), exp_err);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_released_valid"}, int'(out_valid), 0);
    check_eq({tag, "_released_ready"}, int'(in_ready), 1);
  endtask

  task automatic directed(input string tag, input logic [2*S-1:0] w, input int exp_val,
                          input int exp_err, input int stall);
    send_word(w, 0);
    take_word(tag, exp_val, exp_err, stall);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, int'(in_ready), 1);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    check_eq({tag, "_out_data"}, int'(out_data), 0);
    check_eq({tag, "_out_err"}, int'(out_err), 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_digit = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // +1,0,-1,+1 -> 7
    directed("w7", 8'b10_00_01_10, 7, 0, 0);
    // -1 x4 -> -15 ; +1,-1,-1,-1 -> 1
    directed("wm15", 8'b01_01_01_01, -15, 0, 0);
    directed("w1", 8'b10_01_01_01, 1, 0, 0);
    // held word with 5 stall cycles
    directed("stall", 8'b10_10_00_01, 11, 0, 5);
    // illegal digit first -> 4 with error, then a clean word
    directed("ill", 8'b11_10_00_00, 4, 1, 2);
    directed("clean", 8'b00_00_10_10, 3, 0, 0);
    // extremes
    directed("max", 8'b10_10_10_10, 15, 0, 0);

    // rst after 2 digits
    push(2'b10, 0, 1'b0);
    push(2'b01, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_rst");
    directed("after_rst", 8'b00_00_00_10, 1, 0, 0);

    // clr after 2 digits
    push(2'b11, 0, 1'b0);
    push(2'b10, 0, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check_idle("mid_clr");
    directed("after_clr", 8'b00_00_00_10, 1, 0, 0);

    // clr coinciding with the last digit discards the word
    push(2'b10, 0, 1'b0);
    push(2'b10, 0, 1'b0);
    push(2'b10, 0, 1'b0);
    push(2'b10, 0, 1'b1);
    check_idle("clr_last");
    directed("after_clr_last", 8'b01_00_00_00, -8, 0, 0);

    // clr coinciding with the output handshake discards it too
    send_word(8'b10_00_00_00, 0);
    out_ready = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    clr = 1'b0;
    check_idle("clr_hold");

    // rst during HOLD
    send_word(8'b01_01_00_00, 0);
    check_eq("hold_before_rst", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_hold");

    for (int n = 0; n < 10000; n++) begin
      logic [2*S-1:0] w;
      int stall;
      w = (2*S)'($urandom);
      stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      send_word(w, 3);
      take_word("rand", ref_sum(w), ref_err(w), stall);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
